// File: rtl/nios2_oci_dct_capture_if.sv
// Capture-tap bus: trace packer inputs, end-of-test handshake, read port and status.
// The rd_timestamp signal exists only when NIOS2_OCI_DCT_TIMESTAMP_EN is defined.
interface nios2_oci_dct_capture_if #(
    parameter int DCT_WIDTH   = 30,
    parameter int COUNT_WIDTH = 4,
    parameter int DEPTH_LOG2  = 4,
    parameter int DROP_WIDTH  = 8
);
    logic [DCT_WIDTH-1:0]   dct_buffer;
    logic [COUNT_WIDTH-1:0] dct_count;
    logic                   test_ending;
    logic                   test_has_ended;
    logic                   rd_en;
    logic                   rd_valid;
    logic [DCT_WIDTH-1:0]   rd_data;
    logic [COUNT_WIDTH-1:0] rd_count;
    logic [DEPTH_LOG2:0]    level;
    logic                   empty;
    logic                   full;
    logic                   overflow;
    logic [DROP_WIDTH-1:0]  drop_count;
    logic [1:0]             state;
    logic                   done;
    logic                   no_ending;
`ifdef NIOS2_OCI_DCT_TIMESTAMP_EN
    logic [15:0]            rd_timestamp;
`endif

    modport master (
        output dct_buffer, dct_count, test_ending, test_has_ended, rd_en,
        input  rd_valid, rd_data, rd_count, level, empty, full, overflow,
               drop_count, state, done, no_ending
`ifdef NIOS2_OCI_DCT_TIMESTAMP_EN
        , input rd_timestamp
`endif
    );

    modport slave (
        input  dct_buffer, dct_count, test_ending, test_has_ended, rd_en,
        output rd_valid, rd_data, rd_count, level, empty, full, overflow,
               drop_count, state, done, no_ending
`ifdef NIOS2_OCI_DCT_TIMESTAMP_EN
        , output rd_timestamp
`endif
    );
endinterface

// File: rtl/nios2_oci_dct_capture.sv
// DCT trace capture tap: detects packer flushes, queues {count, word} in a
// small FIFO, runs the test_ending / test_has_ended handshake and exposes a
// read port with status. Optional macro NIOS2_OCI_DCT_TIMESTAMP_EN adds a
// 16-bit cycle stamp to every entry and an rd_timestamp output.
module nios2_oci_dct_capture #(
    parameter int DCT_WIDTH   = 30,
    parameter int COUNT_WIDTH = 4,
    parameter int DEPTH_LOG2  = 4,
    parameter int DROP_WIDTH  = 8
) (
    input  logic clk,
    input  logic reset_n,
    nios2_oci_dct_capture_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = COUNT_WIDTH + DCT_WIDTH;
`ifdef NIOS2_OCI_DCT_TIMESTAMP_EN
    localparam int EW    = PW + 16;
`else
    localparam int EW    = PW;
`endif

    typedef enum logic [1:0] {RUN = 2'b00, DRAIN = 2'b01, FROZEN = 2'b10, DONE = 2'b11} state_t;

    state_t                 cur, nxt;
    logic [DCT_WIDTH-1:0]   prev_buffer;
    logic [COUNT_WIDTH-1:0] prev_count;
    logic                   prev_ending;

    logic [EW-1:0]          mem [DEPTH];
    logic [DEPTH_LOG2:0]    wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]    level;
    logic                   empty, full;
    logic                   push_req, pop, push_ok, drop, set_no_ending;
    logic [PW-1:0]          push_payload;
    logic [EW-1:0]          push_word;
    logic [EW-1:0]          rd_word;
    logic                   overflow, no_ending;
    logic [DROP_WIDTH-1:0]  drop_count;

`ifdef NIOS2_OCI_DCT_TIMESTAMP_EN
    logic [15:0]            ts;

    // Free-running cycle stamp; wraps naturally at 16 bits.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ts <= '0;
        else          ts <= ts + 16'd1;
    end

    // Stamp is the counter value in the push cycle (the DRAIN cycle for partial flushes).
    assign push_word = {ts, push_payload};
    assign bus.rd_timestamp = rd_word[EW-1:PW];
`else
    assign push_word = push_payload;
`endif

    // Next-state and push selection: normal flushes only in RUN, partial flush in DRAIN.
    always_comb begin
        nxt           = cur;
        push_req      = 1'b0;
        push_payload  = {prev_count, prev_buffer};
        set_no_ending = 1'b0;
        case (cur)
            RUN: begin
                if (prev_count != '0 && bus.dct_count == '0) push_req = 1'b1;
                // Abrupt end wins over a same-cycle test_ending edge.
                if (bus.test_has_ended) begin
                    nxt           = DONE;
                    set_no_ending = 1'b1;
                end else if (bus.test_ending && !prev_ending) begin
                    nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.dct_count != '0) begin
                    push_req     = 1'b1;
                    push_payload = {bus.dct_count, bus.dct_buffer};
                end
                nxt = FROZEN;
            end
            FROZEN: if (bus.test_has_ended) nxt = DONE;
            default: nxt = DONE;
        endcase
    end

    assign level   = wr_ptr - rd_ptr;
    assign empty   = (level == '0);
    assign full    = (level == (DEPTH_LOG2+1)'(DEPTH));
    assign pop     = bus.rd_en && !empty;
    // A pop in the same cycle frees the slot a full push needs.
    assign push_ok = push_req && (!full || pop);
    assign drop    = push_req && full && !pop;

    // Previous-cycle samples of the packer outputs and test_ending, in every state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_buffer <= '0;
            prev_count  <= '0;
            prev_ending <= 1'b0;
        end else begin
            prev_buffer <= bus.dct_buffer;
            prev_count  <= bus.dct_count;
            prev_ending <= bus.test_ending;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cur <= RUN;
        else          cur <= nxt;
    end

    // FIFO storage and pointers; contents cleared on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_word;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Read port: one-cycle pulse, data holds between pops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.rd_valid <= 1'b0;
            rd_word      <= '0;
        end else begin
            bus.rd_valid <= pop;
            if (pop) rd_word <= mem[rd_ptr[DEPTH_LOG2-1:0]];
        end
    end

    // Sticky overflow, saturating drop counter and no_ending flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
            no_ending  <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + 1'b1;
            end
            if (set_no_ending) no_ending <= 1'b1;
        end
    end

    assign bus.rd_data    = rd_word[DCT_WIDTH-1:0];
    assign bus.rd_count   = rd_word[PW-1:DCT_WIDTH];
    assign bus.level      = level;
    assign bus.empty      = empty;
    assign bus.full       = full;
    assign bus.overflow   = overflow;
    assign bus.drop_count = drop_count;
    assign bus.state      = cur;
    assign bus.done       = (cur == DONE);
    assign bus.no_ending  = no_ending;
endmodule
